// File: rtl/aes_inv_key_schedule_if.sv
// Bundle of load/key handshake signals for the reverse AES-128 key schedule.
// The master side loads the final round key and consumes the round keys.
interface aes_inv_key_schedule_if;
  logic         load_valid;
  logic         load_ready;
  logic [127:0] last_key;
  logic         flush;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_last;

  modport master (
    output load_valid, last_key, flush, key_ready,
    input  load_ready, key_valid, round_key, round_idx, key_last
  );

  modport slave (
    input  load_valid, last_key, flush, key_ready,
    output load_ready, key_valid, round_key, round_idx, key_last
  );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Iterative reverse AES-128 key schedule: takes the round-NR key and streams
// round keys NR down to 0, deriving each previous key on the fly.
module aes_inv_key_schedule #(
  parameter int N  = 4,
  parameter int NR = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  aes_inv_key_schedule_if.slave   bus
);
  localparam int KeySize = N * N * 8;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  typedef enum logic {IDLE, EMIT} state_t;

  state_t               state_q, state_d;
  logic [KeySize-1:0]   key_q, key_d;
  logic [3:0]           round_q, round_d;

  logic [31:0]          w [N];
  logic [31:0]          p [N];
  logic [31:0]          rot_w, sub_w;
  logic [7:0]           rcon;
  logic [KeySize-1:0]   prev_key;

  // Word c packs column c with row 0 in the most-significant byte.
  always_comb begin
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < N; i++) begin
        w[c][31-8*i -: 8] = key_q[8*(i*N+c) +: 8];
      end
    end
  end

  always_comb begin
    unique case (round_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

  assign p[3]  = w[3] ^ w[2];
  assign p[2]  = w[2] ^ w[1];
  assign p[1]  = w[1] ^ w[0];
  assign rot_w = {p[3][23:0], p[3][31:24]};

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      sub_w[8*b +: 8] = SBOX[rot_w[8*b +: 8]];
    end
  end

  assign p[0] = w[0] ^ sub_w ^ {rcon, 24'h0};

  always_comb begin
    prev_key = '0;
    for (int c = 0; c < N; c++) begin
      for (int i = 0; i < N; i++) begin
        prev_key[8*(i*N+c) +: 8] = p[c][31-8*i -: 8];
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    round_d = round_q;
    if (bus.flush) begin
      state_d = IDLE;
      round_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.load_valid) begin
            key_d   = bus.last_key;
            round_d = 4'(NR);
            state_d = EMIT;
          end
        end
        EMIT: begin
          if (bus.key_ready) begin
            if (round_q == '0) begin
              state_d = IDLE;
            end else begin
              key_d   = prev_key;
              round_d = round_q - 4'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  // Outputs depend on registered state only.
  assign bus.load_ready = (state_q == IDLE);
  assign bus.key_valid  = (state_q == EMIT);
  assign bus.round_key  = (state_q == EMIT) ? key_q : '0;
  assign bus.round_idx  = (state_q == EMIT) ? round_q : '0;
  assign bus.key_last   = (state_q == EMIT) && (round_q == '0);
endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Bench for the reverse AES-128 key schedule: an array-based FIPS-197 key
// expansion model predicts every beat, with FIPS literals pinning the model.
module tb_aes_inv_key_schedule;
  logic clk;
  logic rst;
  aes_inv_key_schedule_if bus ();

  aes_inv_key_schedule #(.N(4), .NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [3:0]   idx;
    logic         last;
  } exp_t;

  exp_t         exp_q [$];
  logic [7:0]   sbox_m [256];
  logic [7:0]   rcon_m [11];
  logic [127:0] seen_key [11];
  int           n_checks = 0;
  int           n_pass   = 0;
  logic [127:0] fips_key, alt_key;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s: got timeout/unexpected event expected none", name);
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r ^= x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return r;
  endfunction

  // S-box from its definition: GF(2^8) inverse followed by the affine map.
  task automatic build_tables();
    logic [7:0] inv, s;
    for (int v = 0; v < 256; v++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (v != 0 && gmul(8'(v), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sbox_m[v] = s;
    end
    rcon_m[0] = 8'h00;
    rcon_m[1] = 8'h01;
    for (int i = 2; i <= 10; i++) rcon_m[i] = gmul(rcon_m[i-1], 8'h02);
  endtask

  function automatic logic [127:0] pack4(input logic [31:0] w0, input logic [31:0] w1,
                                         input logic [31:0] w2, input logic [31:0] w3);
    logic [31:0]  ws [4];
    logic [127:0] k = '0;
    ws[0] = w0; ws[1] = w1; ws[2] = w2; ws[3] = w3;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) k[8*(i*4+c) +: 8] = ws[c][31-8*i -: 8];
    return k;
  endfunction

  // Runs the forward expansion recurrence w[i] = w[i-4] ^ temp backwards over
  // the full 44-word schedule, then queues round keys 10..0.
  task automatic push_model(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    exp_t        e;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) w[40+c][31-8*i -: 8] = k[8*(i*4+c) +: 8];
    for (int i = 43; i >= 4; i--) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_m[t[31:24]], sbox_m[t[23:16]], sbox_m[t[15:8]], sbox_m[t[7:0]]};
        t = t ^ {rcon_m[i/4], 24'h0};
      end
      w[i-4] = w[i] ^ t;
    end
    for (int r = 10; r >= 0; r--) begin
      e.key  = pack4(w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]);
      e.idx  = 4'(r);
      e.last = (r == 0);
      exp_q.push_back(e);
    end
  endtask

  // Compare process: every beat against the model, plus hold-stability under stall.
  logic         prev_hold = 1'b0;
  logic [127:0] prev_key;
  logic [3:0]   prev_idx;
  always @(negedge clk) begin
    exp_t e;
    if (rst || bus.flush) begin
      exp_q.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", bus.key_valid, 1'b1);
        check("hold_key", bus.round_key, prev_key);
        check("hold_idx", bus.round_idx, prev_idx);
      end
      if (bus.key_valid && bus.key_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("spurious_beat");
        end else begin
          e = exp_q.pop_front();
          check("beat_key", bus.round_key, e.key);
          check("beat_idx", bus.round_idx, e.idx);
          check("beat_last", bus.key_last, e.last);
        end
      end
      if (bus.load_valid && bus.load_ready) push_model(bus.last_key);
      prev_hold = bus.key_valid && !bus.key_ready;
      prev_key  = bus.round_key;
      prev_idx  = bus.round_idx;
    end
  end

  // mode 0: ready high; 1: random ready with 5-cycle stalls at idx 10/5/0;
  // 2: load_valid held with another key during EMIT; 3: flush after idx 6; 4: reset at idx 3.
  task automatic run_seq(input logic [127:0] k, input int mode);
    int  beats, cycles, stall_left, stalled_idx;
    bit  done;
    bus.last_key   = k;
    bus.load_valid = 1'b1;
    cycles = 0;
    while (!bus.load_ready && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
    end
    if (!bus.load_ready) begin
      fail_now("load_timeout");
      bus.load_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    if (mode == 2) bus.last_key = alt_key;
    else bus.load_valid = 1'b0;
    check("first_valid", bus.key_valid, 1'b1);
    check("first_idx", bus.round_idx, 4'd10);
    check("first_key", bus.round_key, k);

    beats = 0; cycles = 0; stall_left = 0; stalled_idx = -1; done = 0;
    while (!done && cycles < 300) begin
      if (mode == 4 && bus.round_idx == 4'd3) begin
        bus.key_ready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_valid", bus.key_valid, 1'b0);
        check("arst_key", bus.round_key, 128'h0);
        check("arst_ready", bus.load_ready, 1'b1);
        check("arst_idx", bus.round_idx, 4'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.key_ready = 1'b1;
        return;
      end
      if (mode == 1 && (bus.round_idx == 4'd10 || bus.round_idx == 4'd5 || bus.round_idx == 4'd0)
          && int'(bus.round_idx) != stalled_idx) begin
        stall_left  = 5;
        stalled_idx = int'(bus.round_idx);
      end
      if (stall_left > 0) begin
        bus.key_ready = 1'b0;
        stall_left--;
      end else begin
        bus.key_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      @(negedge clk);
      cycles++;
      check("valid_in_seq", bus.key_valid, 1'b1);
      if (bus.key_ready) begin
        if (bus.round_idx <= 4'd10) seen_key[bus.round_idx] = bus.round_key;
        beats++;
      end
      @(posedge clk); #1;
      if (beats == 11 || (mode == 3 && beats == 5)) done = 1;
    end
    if (!done) fail_now("seq_timeout");
    if (mode == 3) begin
      bus.key_ready = 1'b0;
      bus.flush     = 1'b1;
      @(posedge clk); #1;
      bus.flush     = 1'b0;
      check("flush_valid", bus.key_valid, 1'b0);
      check("flush_ready", bus.load_ready, 1'b1);
      check("flush_idx", bus.round_idx, 4'd0);
    end else begin
      check("idle_valid", bus.key_valid, 1'b0);
      check("idle_ready", bus.load_ready, 1'b1);
    end
    bus.key_ready = 1'b1;
  endtask

  initial begin
    rst            = 1'b0;
    bus.load_valid = 1'b0;
    bus.last_key   = '0;
    bus.flush      = 1'b0;
    bus.key_ready  = 1'b1;
    build_tables();
    fips_key = pack4(32'hd014f9a8, 32'hc9ee2589, 32'he13f0cc8, 32'hb6630ca6);
    alt_key  = pack4(32'h00112233, 32'h44556677, 32'h8899aabb, 32'hccddeeff);

    #1 rst = 1'b1;
    #1;
    check("rst_load_ready", bus.load_ready, 1'b1);
    check("rst_key_valid", bus.key_valid, 1'b0);
    check("rst_round_key", bus.round_key, 128'h0);
    check("rst_round_idx", bus.round_idx, 4'd0);
    check("rst_key_last", bus.key_last, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;

    for (int r = 0; r <= 10; r++) seen_key[r] = '0;
    run_seq(fips_key, 0);
    check("fips_idx10", seen_key[10], fips_key);
    check("fips_idx9", seen_key[9], pack4(32'hac7766f3, 32'h19fadc21, 32'h28d12941, 32'h575c006e));
    check("fips_idx1", seen_key[1], pack4(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));
    check("fips_idx0", seen_key[0], pack4(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c));

    run_seq(fips_key, 0);
    check("b2b_idx0", seen_key[0], pack4(32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c));

    run_seq(fips_key, 1);
    check("bp_idx1", seen_key[1], pack4(32'ha0fafe17, 32'h88542cb1, 32'h23a33939, 32'h2a6c7605));

    run_seq(fips_key, 3);
    run_seq(fips_key, 0);

    run_seq(fips_key, 4);
    run_seq(fips_key, 0);

    run_seq(fips_key, 2);
    run_seq(alt_key, 0);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", 128'(exp_q.size()), 128'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Iterative reverse AES-128 key schedule for the decryption datapath.
- Loads the final round key (round Nr) and streams round keys Nr, Nr-1, …, 0 over a valid/ready interface.
- Each emitted key feeds the add-round-key stage of the inverse cipher, using the same 128-bit key bus byte packing.
- Storing all expanded keys is unnecessary.

Parameters:
- N, 4, state dimension; only 4 (AES-128) supported; KeySize = N*N*8 = 128 is a localparam.
- NR, 10, number of rounds; width of round_idx is 4.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- load_valid  input  1  last_key is valid.
- load_ready  output  1  block can accept a new last_key.
- last_key  input  128  round-NR key.
- flush  input  1  synchronous abort to IDLE.
- key_valid  output  1  round_key/round_idx/key_last are valid.
- key_ready  input  1  consumer accepts the current key.
- round_key  output  128  current round key.
- round_idx  output  4  round number of round_key (NR down to 0).
- key_last  output  1  high with round_idx==0.

Behaviour:
- Byte packing matches the cipher key bus.
  - Byte (i,j) (row i, column j) is at key[8*(i*N+j)+:8].
  - Word c = {byte(0,c), byte(1,c), byte(2,c), byte(3,c)}, with row 0 as the most-significant byte of the word.
- States: IDLE, EMIT.
- Reset (async): state=IDLE; key register=0; round=0. Outputs: load_ready=1, key_valid=0, round_key=0, round_idx=0, key_last=0.
- IDLE:
  - load_ready=1, key_valid=0.
  - On load_valid&&load_ready: register last_key, round=NR, go to EMIT.
- EMIT:
  - load_ready=0; key_valid=1; round_key=key register; round_idx=round; key_last=(round==0).
  - round_key, round_idx and key_last hold stable while key_valid&&!key_ready.
  - On key_valid&&key_ready with round==0: go to IDLE. load_ready=1 on the following cycle.
  - On key_valid&&key_ready with round>0: register the previous key, decrement round, stay in EMIT.
  - Throughput is one key per cycle with ready held high, so a full sequence is NR+1 consecutive beats.
- Previous-key computation (combinational, from current words w0..w3 of round r):
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0 ^ SubWord(RotWord(p3)) ^ {Rcon[r],24'h0}
  - RotWord: {a,b,c,d} -> {b,c,d,a}.
  - SubWord: the AES forward S-box on each byte; four table instances inside this block.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36, selected by round via a case table; Rcon is never applied at r=0.
- Latency: load accept cycle N, first key_valid cycle N+1. First key out equals last_key unmodified.
- flush: highest priority after rst. Next state is IDLE, key_valid=0, round=0; any in-progress sequence is discarded. A flush in IDLE has no effect.
- Load is only accepted in IDLE. load_valid during EMIT is ignored, with no buffering.
- No combinational path from key_ready to key_valid or load_ready; from load_valid to load_ready; or from any input to round_key.

Test Plan:
- Key values are FIPS-197 Appendix A.1 words w0..w3, packed onto the bus per the byte map. key_ready is held high for the first two scenarios.
- FIPS sequence:
  - Stimulus: load round-10 key d014f9a8 c9ee2589 e13f0cc8 b6630ca6.
  - Expected: round_idx 10 emits that key; idx 9 = ac7766f3 19fadc21 28d12941 575c006e; idx 1 = a0fafe17 88542cb1 23a33939 2a6c7605; idx 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c with key_last=1.
  - Timing: exactly 11 beats, then load_ready=1 the next cycle.
- Back-to-back:
  - Stimulus: reload the same key in the first IDLE cycle after the idx-0 beat.
  - Expected: second sequence identical to the first; no spurious beats between sequences.
- Backpressure:
  - Stimulus: toggle key_ready randomly, including 5-cycle stalls at idx 10, 5 and 0.
  - Expected: round_key/round_idx stable during stalls; the same 11 keys arrive in order.
- Flush:
  - Stimulus: assert flush for one cycle after the idx-6 beat.
  - Expected: key_valid=0 the next cycle, load_ready=1.
  - Follow-up: a new load restarts at idx 10 with correct keys.
- Async reset:
  - Stimulus: assert rst mid-cycle during EMIT at idx 3.
  - Expected: outputs immediately show key_valid=0, round_key=0, load_ready=1, without waiting for a clock edge.
  - Follow-up: after release, a full FIPS sequence passes.
- Ignored load:
  - Stimulus: hold load_valid=1 with a different key throughout EMIT.
  - Expected: the sequence is unaffected. The new key is accepted only in the IDLE cycle after idx 0.
